// File: rtl/logicalstep_cmd_handshake.sv
// Four-phase command handshake between fabric logic and the Nios II PIO.
// Presents request/code, waits for response rise then fall, flags done/timeout.
module logicalstep_cmd_handshake #(
    parameter int CMD_W          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             request_out,
    output logic [CMD_W-1:0] cmd_code_out,
    input  logic             response_in,
    output logic             done_pulse,
    output logic             timeout_pulse,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE,
        DRAIN
    } state_t;

    state_t             state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               resp_s;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               req_d;
    logic [CMD_W-1:0]   code_d;
    logic               done_d;
    logic               tmo_d;
    logic               last;

    assign resp_s = sync_q[SYNC_STAGES-1];
    assign last   = (cnt == CNT_LAST);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= response_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            request_out   <= 1'b0;
            cmd_code_out  <= '0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            request_out   <= req_d;
            cmd_code_out  <= code_d;
            done_pulse    <= done_d;
            timeout_pulse <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state;
        req_d     = request_out;
        code_d    = cmd_code_out;
        done_d    = 1'b0;
        tmo_d     = 1'b0;
        cmd_ready = (state == IDLE) & ~resp_s;
        unique case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    code_d  = cmd_data;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // a response seen on the terminal count still wins
                if (resp_s) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end else if (last) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            RELEASE: begin
                if (!resp_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (last) begin
                    tmo_d   = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!resp_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // phase counter restarts on every state entry; terminal count forces exit
    always_comb begin
        cnt_d = cnt;
        if (state_d != state) begin
            cnt_d = '0;
        end else if (state == REQ || state == RELEASE) begin
            cnt_d = cnt + 1'b1;
        end
    end

endmodule

// File: doc/logicalstep_cmd_handshake.md
Name: logicalstep_cmd_handshake

Overview:
- Fabric-side four-phase handshake controller that consumes the 1-bit response PIO output driven by the Nios II.
- Presents a command code and request bit to the CPU through PIO inputs.
- Waits for the CPU to raise and then drop its response bit, and reports completion or timeout back to fabric logic (button/switch decoder, audio control).
- Sits directly downstream of the response PIO out_port.

Parameters:
- CMD_W, 4, width of command code.
- SYNC_STAGES, 2, flops on response_in before use (legal 1..3).
- TIMEOUT_CYCLES, 50000000, cycles allowed per handshake phase (1 s at 50 MHz); legal ≥2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  fabric has a command to send.
- cmd_data  in  CMD_W  command code, sampled when cmd_valid & cmd_ready.
- cmd_ready  out  1  block accepts a command this cycle.
- request_out  out  1  to CPU PIO input: command pending.
- cmd_code_out  out  CMD_W  to CPU PIO input: registered command code.
- response_in  in  1  from response PIO out_port.
- done_pulse  out  1  one-cycle pulse, handshake completed.
- timeout_pulse  out  1  one-cycle pulse, phase timed out.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; request_out=0, cmd_code_out=0, done_pulse=0, timeout_pulse=0, busy=0, sync chain=0, counter=0. Reset mid-handshake aborts silently, with no pulses.
- resp_s = response_in after SYNC_STAGES flops. All decisions use resp_s only.
- States: IDLE, REQ, RELEASE, DRAIN. The phase counter clears on every state entry and increments each cycle in REQ and RELEASE.
- IDLE:
  - cmd_ready = (state==IDLE) & ~resp_s (combinational).
  - A stale high response blocks acceptance.
  - On cmd_valid & cmd_ready: cmd_code_out<=cmd_data, request_out<=1, go to REQ. request_out is high on the cycle after acceptance.
- REQ:
  - resp_s==1 → request_out<=0, go to RELEASE.
  - Otherwise, counter==TIMEOUT_CYCLES-1 → request_out<=0, timeout_pulse for 1 cycle, go to DRAIN.
- RELEASE:
  - resp_s==0 → done_pulse for 1 cycle, go to IDLE.
  - Otherwise, counter==TIMEOUT_CYCLES-1 → timeout_pulse, go to DRAIN.
- DRAIN:
  - No timeout.
  - resp_s==0 → IDLE, with no done_pulse.
- Simultaneous response change and counter terminal value: the response wins (no timeout).
- cmd_code_out holds its value from capture until the next accepted command, including through IDLE.
- done_pulse and timeout_pulse are registered, never high together, and each is high for exactly 1 cycle per event.
- Latency:
  - response_in rises at edge t → resp_s high after SYNC_STAGES edges → request_out low on the following edge.
  - Earliest next acceptance is the cycle after returning to IDLE.
- cmd_valid held high continuously: one command is accepted per completed handshake. cmd_data is not re-sampled until cmd_ready is high again.
- Counter width: ceil(log2(TIMEOUT_CYCLES)); it never wraps.

Test Plan:
- Normal handshake (SYNC_STAGES=2, TIMEOUT_CYCLES=16):
  - Stimulus: cmd_valid=1 and cmd_data=4'hA for 1 cycle; response_in rises 5 cycles after request_out; response_in falls 3 cycles after request_out drops.
  - Required: cmd_code_out=4'hA; request_out high until 3 edges after response_in rises; done_pulse exactly once, 3 edges after response_in falls; busy low afterward.
- Stale response:
  - Stimulus: response_in held 1 in IDLE, cmd_valid=1.
  - Required: cmd_ready=0, no capture; drop response_in → cmd_ready=1 two edges later and the command is accepted.
- REQ timeout (TIMEOUT_CYCLES=16):
  - Stimulus: response_in never rises.
  - Required: request_out falls and timeout_pulse is high exactly 16 cycles after REQ entry; state DRAIN→IDLE next cycle; no done_pulse.
- RELEASE timeout:
  - Stimulus: response_in rises and stays high.
  - Required: timeout_pulse 16 cycles after RELEASE entry; busy stays high (DRAIN) until response_in drops; then IDLE with no done_pulse.
- Back-to-back:
  - Stimulus: cmd_valid held 1 with cmd_data 3 then 7 across two handshakes.
  - Required: two done_pulses; cmd_code_out=3, then 7, with each change only on acceptance.
- Reset mid-REQ:
  - Stimulus: assert reset_n=0 asynchronously.
  - Required: request_out=0, cmd_code_out=0, busy=0 immediately, before the next clk edge; no pulses after release.
